// File: rtl/lifo_stack.sv
// Synchronous LIFO stack of 2**AWIDTH words with registered pop data, fill count and flags.
// Flags are registered from the next fill count so they change together with usedw_o.
module lifo_stack #(
    parameter int unsigned DWIDTH       = 16,
    parameter int unsigned AWIDTH       = 8,
    parameter int unsigned ALMOST_FULL  = 2,
    parameter int unsigned ALMOST_EMPTY = 2
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              wrreq_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              almost_full_o,
    output logic              almost_empty_o
);

    localparam int unsigned Depth = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] MaxCount = {1'b1, {AWIDTH{1'b0}}};

    logic [DWIDTH-1:0] mem [Depth];

    logic [AWIDTH:0]   usedw_q, usedw_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              afull_q, afull_d;
    logic              aempty_q, aempty_d;
    logic [DWIDTH-1:0] q_q;

    logic              pop_ok;
    logic              push_ok;
    logic [AWIDTH-1:0] top_addr;
    logic [AWIDTH-1:0] wr_addr;

    assign pop_ok   = rdreq_i && !empty_q;
    assign push_ok  = wrreq_i && !full_q;
    // When full the low bits are zero, so the decrement wraps to Depth-1 as intended.
    assign top_addr = usedw_q[AWIDTH-1:0] - 1'b1;
    // A simultaneous pop frees the top slot, which the push then reuses.
    assign wr_addr  = pop_ok ? top_addr : usedw_q[AWIDTH-1:0];

    always_comb begin
        usedw_d = usedw_q;
        if (push_ok && !pop_ok) begin
            usedw_d = usedw_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            usedw_d = usedw_q - 1'b1;
        end
        empty_d  = (usedw_d == '0);
        full_d   = (usedw_d == MaxCount);
        afull_d  = (32'(usedw_d) >= ALMOST_FULL);
        aempty_d = (32'(usedw_d) <= ALMOST_EMPTY);
    end

    always_ff @(posedge clk_i or negedge srst_i) begin
        if (!srst_i) begin
            usedw_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= (ALMOST_FULL == 0);
            aempty_q <= 1'b1;
        end else begin
            usedw_q  <= usedw_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    // Storage and pop data are deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (pop_ok) begin
            q_q <= mem[top_addr];
        end
        if (push_ok) begin
            mem[wr_addr] <= data_i;
        end
    end

    assign q_o            = q_q;
    assign usedw_o        = usedw_q;
    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign almost_full_o  = afull_q;
    assign almost_empty_o = aempty_q;

endmodule

// File: tb/tb_lifo_stack.sv
// Directed and randomised self-checking bench for lifo_stack (DWIDTH=16, AWIDTH=8).
module tb_lifo_stack;

    logic        clk_i = 1'b0;
    logic        srst_i = 1'b0;
    logic [15:0] data_i = '0;
    logic        wrreq_i = 1'b0;
    logic        rdreq_i = 1'b0;
    logic [15:0] q_o;
    logic        empty_o, full_o, almost_full_o, almost_empty_o;
    logic [8:0]  usedw_o;

    int n_cmp = 0;
    int n_err = 0;

    lifo_stack #(
        .DWIDTH(16),
        .AWIDTH(8),
        .ALMOST_FULL(2),
        .ALMOST_EMPTY(2)
    ) dut (
        .clk_i(clk_i),
        .srst_i(srst_i),
        .data_i(data_i),
        .wrreq_i(wrreq_i),
        .rdreq_i(rdreq_i),
        .q_o(q_o),
        .empty_o(empty_o),
        .full_o(full_o),
        .usedw_o(usedw_o),
        .almost_full_o(almost_full_o),
        .almost_empty_o(almost_empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic flags(input string tag, input int uw, input logic e, input logic f,
                         input logic af, input logic ae);
        chk({tag, ".usedw"}, 32'(usedw_o), 32'(uw));
        chk({tag, ".empty"}, 32'(empty_o), 32'(e));
        chk({tag, ".full"}, 32'(full_o), 32'(f));
        chk({tag, ".afull"}, 32'(almost_full_o), 32'(af));
        chk({tag, ".aempty"}, 32'(almost_empty_o), 32'(ae));
    endtask

    task automatic cyc(input logic w, input logic r, input logic [15:0] d);
        @(negedge clk_i);
        wrreq_i = w;
        rdreq_i = r;
        data_i  = d;
        @(posedge clk_i);
        #1;
        wrreq_i = 1'b0;
        rdreq_i = 1'b0;
    endtask

    initial begin
        logic [15:0] model[$];
        logic [15:0] exp_q;
        logic        w, r, pop_ok, push_ok;
        logic [15:0] d;

        // Reset and idle
        repeat (2) @(posedge clk_i);
        #1;
        flags("in_reset", 0, 1, 0, 0, 1);
        @(negedge clk_i);
        srst_i = 1'b1;
        cyc(0, 0, 16'h0);
        flags("idle", 0, 1, 0, 0, 1);

        // Basic push/pop order
        cyc(1, 0, 16'h1111);
        flags("push1", 1, 0, 0, 0, 1);
        cyc(1, 0, 16'h2222);
        flags("push2", 2, 0, 0, 1, 1);
        cyc(1, 0, 16'h3333);
        flags("push3", 3, 0, 0, 1, 0);
        cyc(0, 1, 16'h0);
        chk("pop1.q", 32'(q_o), 32'h3333);
        flags("pop1", 2, 0, 0, 1, 1);
        cyc(0, 1, 16'h0);
        chk("pop2.q", 32'(q_o), 32'h2222);
        cyc(0, 1, 16'h0);
        chk("pop3.q", 32'(q_o), 32'h1111);
        flags("pop3", 0, 1, 0, 0, 1);

        // Empty-stack corner cases
        cyc(0, 1, 16'h0);
        chk("pop_empty.q", 32'(q_o), 32'h1111);
        chk("pop_empty.usedw", 32'(usedw_o), 0);
        cyc(1, 1, 16'h5555);
        chk("pp_empty.q", 32'(q_o), 32'h1111);
        flags("pp_empty", 1, 0, 0, 0, 1);
        cyc(0, 1, 16'h0);
        chk("pp_empty_pop.q", 32'(q_o), 32'h5555);

        // Simultaneous push/pop in the middle
        for (int i = 0; i < 5; i++) cyc(1, 0, 16'(16'h0010 + i));
        chk("mid.usedw", 32'(usedw_o), 5);
        cyc(1, 1, 16'hABCD);
        chk("mid_pp.q", 32'(q_o), 32'h0014);
        chk("mid_pp.usedw", 32'(usedw_o), 5);
        cyc(0, 1, 16'h0);
        chk("mid_pop.q", 32'(q_o), 32'hABCD);
        chk("mid_pop.usedw", 32'(usedw_o), 4);
        for (int i = 0; i < 4; i++) cyc(0, 1, 16'h0);
        chk("drain.q", 32'(q_o), 32'h0010);
        flags("drain", 0, 1, 0, 0, 1);

        // Fill to capacity
        for (int i = 0; i < 256; i++) begin
            cyc(1, 0, 16'(i * 3 + 7));
            if (i == 254) flags("fill255", 255, 0, 0, 1, 0);
        end
        flags("full", 256, 0, 1, 1, 0);
        cyc(1, 0, 16'hDEAD);
        chk("push_full.usedw", 32'(usedw_o), 256);
        cyc(1, 1, 16'hBEEF);
        chk("pp_full.q", 32'(q_o), 32'h0304);
        flags("pp_full", 255, 0, 0, 1, 0);
        cyc(0, 1, 16'h0);
        chk("after_full.q", 32'(q_o), 32'h0301);

        // Asynchronous reset mid-burst
        @(negedge clk_i);
        srst_i = 1'b0;
        #1;
        flags("rst1", 0, 1, 0, 0, 1);
        @(negedge clk_i);
        srst_i = 1'b1;
        for (int i = 0; i < 100; i++) cyc(1, 0, 16'(16'h4000 + i));
        chk("pre_rst.usedw", 32'(usedw_o), 100);
        @(negedge clk_i);
        wrreq_i = 1'b1;
        data_i  = 16'h4444;
        @(posedge clk_i);
        #3;
        chk("burst.usedw", 32'(usedw_o), 101);
        srst_i = 1'b0;
        #1;
        flags("rst_async", 0, 1, 0, 0, 1);
        wrreq_i = 1'b0;
        @(negedge clk_i);
        srst_i = 1'b1;
        cyc(1, 0, 16'h7777);
        chk("resume.usedw", 32'(usedw_o), 1);
        cyc(0, 1, 16'h0);
        chk("resume.q", 32'(q_o), 32'h7777);
        flags("resume", 0, 1, 0, 0, 1);

        // Random traffic against a queue model
        exp_q = 16'h7777;
        for (int i = 0; i < 512; i++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 2) == 0);
            d = 16'($urandom);
            pop_ok  = r && (model.size() > 0);
            push_ok = w && (model.size() < 256);
            if (pop_ok) exp_q = model.pop_back();
            if (push_ok) model.push_back(d);
            cyc(w, r, d);
            chk("rnd.q", 32'(q_o), 32'(exp_q));
            chk("rnd.usedw", 32'(usedw_o), 32'(model.size()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
